// File: rtl/layer_sched.sv
// layer_sched: descriptor FIFO feeding a check/issue/wait scheduler for convolution layers.
// Optional feature macro LAYER_SCHED_CHAIN_EN: chained layers read the previous layer's output address.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module layer_sched #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = `XLEN
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic [ADDR_WIDTH-1:0] push_feature_baseaddr,
   input  logic [ADDR_WIDTH-1:0] push_kernel_baseaddr,
   input  logic [ADDR_WIDTH-1:0] push_output_baseaddr,
   input  logic [DATA_WIDTH-1:0] push_feature_width,
   input  logic [DATA_WIDTH-1:0] push_feature_height,
   input  logic [DATA_WIDTH-1:0] push_feature_chin,
   input  logic [DATA_WIDTH-1:0] push_feature_chout,
   input  logic [DATA_WIDTH-1:0] push_kernel_sizeh,
   input  logic [DATA_WIDTH-1:0] push_kernel_sizew,
   input  logic [DATA_WIDTH-1:0] push_stride,
   input  logic                  push_has_bias,
   input  logic                  push_has_relu,
   input  logic                  push_chain,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [7:0]            layers_done,
   output logic [ADDR_WIDTH-1:0] feature_baseaddr,
   output logic [ADDR_WIDTH-1:0] kernel_baseaddr,
   output logic [ADDR_WIDTH-1:0] output_baseaddr,
   output logic [DATA_WIDTH-1:0] feature_width,
   output logic [DATA_WIDTH-1:0] feature_height,
   output logic [DATA_WIDTH-1:0] feature_chin,
   output logic [DATA_WIDTH-1:0] feature_chout,
   output logic [DATA_WIDTH-1:0] kernel_sizeh,
   output logic [DATA_WIDTH-1:0] kernel_sizew,
   output logic [DATA_WIDTH-1:0] stride,
   output logic [DATA_WIDTH-1:0] output_width,
   output logic [DATA_WIDTH-1:0] output_height,
   output logic                  has_bias,
   output logic                  has_relu,
   output logic                  csrcmd_valid,
   input  logic                  instgen_ready,
   input  logic                  conv_complete
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] fa, ka, oa;
      logic [DATA_WIDTH-1:0] fw, fh, ci, co, kh, kw, st;
      logic                  bias, relu, chain;
   } desc_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] fa, ka, oa;
      logic [DATA_WIDTH-1:0] fw, fh, ci, co, kh, kw, st, ow, oh;
      logic                  bias, relu;
   } cmd_t;

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t          state_q, state_d;
   desc_t           mem_q [DEPTH];
   desc_t           wr_desc, head;
   cmd_t            cmd_q, cmd_d;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            push_ready_q, busy_q, done_q, err_q, valid_q;
   logic [7:0]      layers_q;
   logic            push_fire, pop, load, err_set, run_start, cc_hit, head_ok;
   logic [DATA_WIDTH-1:0] feat_sel;

   assign wr_desc = '{fa: push_feature_baseaddr, ka: push_kernel_baseaddr, oa: push_output_baseaddr,
                      fw: push_feature_width, fh: push_feature_height, ci: push_feature_chin,
                      co: push_feature_chout, kh: push_kernel_sizeh, kw: push_kernel_sizew,
                      st: push_stride, bias: push_has_bias, relu: push_has_relu, chain: push_chain};
   assign head      = mem_q[rd_ptr_q];
   assign push_fire = push_valid && push_ready_q;
   assign count_d   = count_q + CW'(push_fire) - CW'(pop);
   assign head_ok   = (head.st == DATA_WIDTH'(1) || head.st == DATA_WIDTH'(2)) &&
                      (head.kw <= head.fw) && (head.kh <= head.fh);

`ifdef LAYER_SCHED_CHAIN_EN
   // Chaining only applies after the first issued layer of the current run.
   logic                  first_q;
   logic [ADDR_WIDTH-1:0] prev_out_q;
   assign feat_sel = (head.chain && !first_q) ? prev_out_q : head.fa;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q    <= 1'b1;
         prev_out_q <= '0;
      end else if (run_start) begin
         first_q    <= 1'b1;
      end else if (load) begin
         first_q    <= 1'b0;
         prev_out_q <= head.oa;
      end
   end
`else
   logic unused_chain;
   assign unused_chain = head.chain;
   assign feat_sel     = head.fa;
`endif

   always_comb begin
      cmd_d    = cmd_q;
      cmd_d.fa = feat_sel;
      cmd_d.ka = head.ka;   cmd_d.oa = head.oa;
      cmd_d.fw = head.fw;   cmd_d.fh = head.fh;
      cmd_d.ci = head.ci;   cmd_d.co = head.co;
      cmd_d.kh = head.kh;   cmd_d.kw = head.kw;
      cmd_d.st = head.st;
      cmd_d.ow = ((head.fw - head.kw) >> (head.st == DATA_WIDTH'(2))) + DATA_WIDTH'(1);
      cmd_d.oh = ((head.fh - head.kh) >> (head.st == DATA_WIDTH'(2))) + DATA_WIDTH'(1);
      cmd_d.bias = head.bias;
      cmd_d.relu = head.relu;
   end

   // Next-state logic; emptiness is judged after this cycle's push/pop.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = (count_q != '0) ? S_CHECK : S_DONE;
         S_CHECK: if (head_ok) state_d = S_ISSUE;
                  else         state_d = (count_d != '0) ? S_CHECK : S_DONE;
         S_ISSUE: if (valid_q && instgen_ready) state_d = S_WAIT;
         S_WAIT:  if (conv_complete) state_d = (count_d != '0) ? S_CHECK : S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      run_start = 1'b0;
      load      = 1'b0;
      pop       = 1'b0;
      err_set   = 1'b0;
      cc_hit    = 1'b0;
      unique case (state_q)
         S_IDLE:  run_start = start;
         S_CHECK: if (head_ok) load = 1'b1;
                  else begin pop = 1'b1; err_set = 1'b1; end
         S_ISSUE: pop = valid_q && instgen_ready;
         S_WAIT:  cc_hit = conv_complete;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_fire) mem_q[wr_ptr_q] <= wr_desc;
   end

   // csrcmd_valid rises one cycle after the command registers load, so they are settled first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         push_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         valid_q      <= 1'b0;
         layers_q     <= '0;
         cmd_q        <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         push_ready_q <= (count_d != CW'(DEPTH));
         busy_q       <= (state_d != S_IDLE);
         done_q       <= (state_d == S_DONE);
         valid_q      <= (state_q == S_ISSUE) && !(valid_q && instgen_ready);
         if (push_fire) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)       rd_ptr_q <= rd_ptr_q + PW'(1);
         if (load)      cmd_q    <= cmd_d;
         if (run_start)    err_q <= 1'b0;
         else if (err_set) err_q <= 1'b1;
         if (run_start)                           layers_q <= '0;
         else if (cc_hit && layers_q != 8'hFF)    layers_q <= layers_q + 8'd1;
      end
   end

   assign push_ready       = push_ready_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign err              = err_q;
   assign layers_done      = layers_q;
   assign csrcmd_valid     = valid_q;
   assign feature_baseaddr = cmd_q.fa;
   assign kernel_baseaddr  = cmd_q.ka;
   assign output_baseaddr  = cmd_q.oa;
   assign feature_width    = cmd_q.fw;
   assign feature_height   = cmd_q.fh;
   assign feature_chin     = cmd_q.ci;
   assign feature_chout    = cmd_q.co;
   assign kernel_sizeh     = cmd_q.kh;
   assign kernel_sizew     = cmd_q.kw;
   assign stride           = cmd_q.st;
   assign output_width     = cmd_q.ow;
   assign output_height    = cmd_q.oh;
   assign has_bias         = cmd_q.bias;
   assign has_relu         = cmd_q.relu;
endmodule

// File: tb/tb_layer_sched.sv
// Scoreboard bench for layer_sched: directed descriptors, expected commands queued at push time.
module tb_layer_sched;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic [AW-1:0] fa, ka, oa;
      logic [DW-1:0] fw, fh, ci, co, kh, kw, st;
      logic          bias, relu, chain;
   } tdesc_t;

   typedef struct {
      logic [AW-1:0] fa, ka, oa;
      logic [DW-1:0] ow, oh, ci, co;
      logic          bias, relu;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n, push_valid, push_ready, start, busy, done, err;
   logic [7:0] layers_done;
   tdesc_t pd;
   logic [AW-1:0] feature_baseaddr, kernel_baseaddr, output_baseaddr;
   logic [DW-1:0] feature_width, feature_height, feature_chin, feature_chout;
   logic [DW-1:0] kernel_sizeh, kernel_sizew, stride, output_width, output_height;
   logic has_bias, has_relu, csrcmd_valid, instgen_ready, conv_complete;

   layer_sched #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_ready(push_ready),
      .push_feature_baseaddr(pd.fa), .push_kernel_baseaddr(pd.ka), .push_output_baseaddr(pd.oa),
      .push_feature_width(pd.fw), .push_feature_height(pd.fh), .push_feature_chin(pd.ci),
      .push_feature_chout(pd.co), .push_kernel_sizeh(pd.kh), .push_kernel_sizew(pd.kw),
      .push_stride(pd.st), .push_has_bias(pd.bias), .push_has_relu(pd.relu), .push_chain(pd.chain),
      .start(start), .busy(busy), .done(done), .err(err), .layers_done(layers_done),
      .feature_baseaddr(feature_baseaddr), .kernel_baseaddr(kernel_baseaddr),
      .output_baseaddr(output_baseaddr), .feature_width(feature_width),
      .feature_height(feature_height), .feature_chin(feature_chin), .feature_chout(feature_chout),
      .kernel_sizeh(kernel_sizeh), .kernel_sizew(kernel_sizew), .stride(stride),
      .output_width(output_width), .output_height(output_height), .has_bias(has_bias),
      .has_relu(has_relu), .csrcmd_valid(csrcmd_valid), .instgen_ready(instgen_ready),
      .conv_complete(conv_complete));

   always #5 clk = ~clk;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_issue = 0;
   bit   auto_cc = 1'b1;
   bit   cc_pending = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: compares every accepted command with the scoreboard head, then answers conv_complete.
   initial begin
      exp_t e;
      conv_complete = 1'b0;
      forever begin
         @(negedge clk);
         if (conv_complete) conv_complete = 1'b0;
         else if (cc_pending && auto_cc) begin conv_complete = 1'b1; cc_pending = 1'b0; end
         if (rst_n && csrcmd_valid && instgen_ready) begin
            n_issue++;
            cc_pending = 1'b1;
            if (sb_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_issue: got command fa=0x%0h, expected none", feature_baseaddr);
            end else begin
               e = sb_q.pop_front();
               check("cmd_feature_base", 64'(feature_baseaddr), 64'(e.fa));
               check("cmd_kernel_base",  64'(kernel_baseaddr),  64'(e.ka));
               check("cmd_output_base",  64'(output_baseaddr),  64'(e.oa));
               check("cmd_output_width", 64'(output_width),     64'(e.ow));
               check("cmd_output_height",64'(output_height),    64'(e.oh));
               check("cmd_chin",         64'(feature_chin),     64'(e.ci));
               check("cmd_chout",        64'(feature_chout),    64'(e.co));
               check("cmd_flags",        64'({has_bias, has_relu}), 64'({e.bias, e.relu}));
            end
         end
      end
   end

   function automatic tdesc_t mk(input logic [AW-1:0] fa, oa, input int fw, fh, kh, kw, st,
                                 input bit chain);
      tdesc_t d;
      d.fa = fa; d.ka = fa + 32'h800; d.oa = oa;
      d.fw = DW'(fw); d.fh = DW'(fh); d.ci = DW'(3); d.co = DW'(64);
      d.kh = DW'(kh); d.kw = DW'(kw); d.st = DW'(st);
      d.bias = fw[0]; d.relu = 1'b1; d.chain = chain;
      return d;
   endfunction

   task automatic push_desc(input tdesc_t d, input bit exp_issue, input logic [AW-1:0] exp_fa,
                            input int exp_ow, input int exp_oh);
      int t = 0;
      if (exp_issue)
         sb_q.push_back('{fa: exp_fa, ka: d.ka, oa: d.oa, ow: DW'(exp_ow), oh: DW'(exp_oh),
                          ci: d.ci, co: d.co, bias: d.bias, relu: d.relu});
      @(negedge clk);
      pd = d;
      push_valid = 1'b1;
      while (!push_ready && t < 200) begin @(negedge clk); t++; end
      if (!push_ready) begin
         n_vec++; n_err++;
         $display("FAIL push_timeout: push_ready still 0 after %0d cycles, expected 1", t);
         push_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 push_valid = 1'b0;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int t = 0;
      do begin @(negedge clk); t++; end while (!done && t < budget);
      n_vec++;
      if (!done) begin
         n_err++;
         $display("FAIL %s_done: done=0 after %0d cycles, expected 1", name, t);
      end else begin
         @(negedge clk);
         check({name, "_done_width"}, 64'(done), 64'd0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int t;
      bit saw_done;
      rst_n = 1'b0; push_valid = 1'b0; start = 1'b0; instgen_ready = 1'b1; pd = '0;
      repeat (3) @(negedge clk);
      check("rst_push_ready", 64'(push_ready), 64'd1);
      check("rst_busy",       64'(busy),       64'd0);
      check("rst_done",       64'(done),       64'd0);
      check("rst_err",        64'(err),        64'd0);
      check("rst_layers",     64'(layers_done), 64'd0);
      check("rst_valid",      64'(csrcmd_valid), 64'd0);
      rst_n = 1'b1;

      // 28x28, 3x3, stride 1 -> 26x26; latency from start sample edge
      base = n_issue;
      push_desc(mk(32'h1000, 32'h3000, 28, 28, 3, 3, 1, 1'b0), 1'b1, 32'h1000, 26, 26);
      pulse_start();
      @(negedge clk); check("busy_after_start", 64'(busy), 64'd1);
      @(negedge clk); check("valid_edge_n1", 64'(csrcmd_valid), 64'd0);
      @(negedge clk); check("valid_edge_n2", 64'(csrcmd_valid), 64'd1);
      wait_done("s1", 100);
      check("s1_layers", 64'(layers_done), 64'd1);
      check("s1_issues", 64'(n_issue - base), 64'd1);
      check("s1_idle_busy", 64'(busy), 64'd0);

      // stride 2 -> 13x13
      push_desc(mk(32'h1100, 32'h3100, 28, 28, 3, 3, 2, 1'b0), 1'b1, 32'h1100, 13, 13);
      pulse_start();
      wait_done("s2", 100);
      check("s2_layers", 64'(layers_done), 64'd1);
      check("s2_err", 64'(err), 64'd0);

      // fill the queue, fifth push lands after the first pop of the run
      base = n_issue;
      push_desc(mk(32'h2000, 32'h4000, 16, 8, 3, 1, 1, 1'b0), 1'b1, 32'h2000, 16, 6);
      push_desc(mk(32'h2100, 32'h4100, 10, 10, 5, 5, 2, 1'b0), 1'b1, 32'h2100, 3, 3);
      push_desc(mk(32'h2200, 32'h4200, 7, 9, 3, 7, 1, 1'b0), 1'b1, 32'h2200, 1, 7);
      push_desc(mk(32'h2300, 32'h4300, 32, 32, 1, 1, 2, 1'b0), 1'b1, 32'h2300, 16, 16);
      @(negedge clk); check("full_push_ready", 64'(push_ready), 64'd0);
      fork
         push_desc(mk(32'h2400, 32'h4400, 28, 28, 3, 3, 1, 1'b0), 1'b1, 32'h2400, 26, 26);
         pulse_start();
      join
      wait_done("fill", 400);
      check("fill_layers", 64'(layers_done), 64'd5);
      check("fill_issues", 64'(n_issue - base), 64'd5);
      check("fill_ready", 64'(push_ready), 64'd1);

      // invalid stride and oversize kernel are skipped with err
      base = n_issue;
      push_desc(mk(32'h5000, 32'h6000, 28, 28, 3, 3, 3, 1'b0), 1'b0, '0, 0, 0);
      push_desc(mk(32'h5100, 32'h6100, 8, 8, 9, 3, 1, 1'b0), 1'b0, '0, 0, 0);
      push_desc(mk(32'h5200, 32'h6200, 28, 28, 3, 3, 1, 1'b0), 1'b1, 32'h5200, 26, 26);
      pulse_start();
      @(negedge clk); @(negedge clk); check("inv_err_set", 64'(err), 64'd1);
      wait_done("inv", 200);
      check("inv_err", 64'(err), 64'd1);
      check("inv_layers", 64'(layers_done), 64'd1);
      check("inv_issues", 64'(n_issue - base), 64'd1);

      // chaining: first layer keeps its own address even with chain set
      push_desc(mk(32'h0100, 32'h10000, 12, 12, 3, 3, 1, 1'b1), 1'b1, 32'h0100, 10, 10);
`ifdef LAYER_SCHED_CHAIN_EN
      push_desc(mk(32'h0, 32'h20000, 10, 10, 3, 3, 1, 1'b1), 1'b1, 32'h10000, 8, 8);
`else
      push_desc(mk(32'h0, 32'h20000, 10, 10, 3, 3, 1, 1'b1), 1'b1, 32'h0, 8, 8);
`endif
      pulse_start();
      wait_done("chain", 200);
      check("chain_layers", 64'(layers_done), 64'd2);
      check("chain_err_cleared", 64'(err), 64'd0);

      // reset while waiting on conv_complete with two more queued
      auto_cc = 1'b0;
      base = n_issue;
      push_desc(mk(32'h7000, 32'h8000, 28, 28, 3, 3, 1, 1'b0), 1'b1, 32'h7000, 26, 26);
      pulse_start();
      t = 0;
      while (n_issue == base && t < 50) begin @(negedge clk); t++; end
      check("rst_run_issued", 64'(n_issue - base), 64'd1);
      push_desc(mk(32'h7100, 32'h8100, 28, 28, 3, 3, 1, 1'b0), 1'b0, '0, 0, 0);
      push_desc(mk(32'h7200, 32'h8200, 28, 28, 3, 3, 1, 1'b0), 1'b0, '0, 0, 0);
      @(negedge clk);
      check("pre_rst_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_push_ready", 64'(push_ready), 64'd1);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_valid", 64'(csrcmd_valid), 64'd0);
      cc_pending = 1'b0;
      auto_cc = 1'b1;
      saw_done = 1'b0;
      repeat (2) begin @(negedge clk); saw_done |= done; end
      rst_n = 1'b1;
      repeat (4) begin @(negedge clk); saw_done |= done; end
      check("midrst_no_done", 64'(saw_done), 64'd0);
      check("midrst_layers", 64'(layers_done), 64'd0);

      // start on empty queue: done next cycle, nothing issued
      base = n_issue;
      pulse_start();
      @(negedge clk);
      check("empty_done", 64'(done), 64'd1);
      check("empty_valid", 64'(csrcmd_valid), 64'd0);
      @(negedge clk);
      check("empty_done_width", 64'(done), 64'd0);
      check("empty_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      check("empty_issues", 64'(n_issue - base), 64'd0);
      check("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
